muldiv_seq: RTL

Iterative RV32M sequencer for the execute stage. It accepts one M-type operation (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) at a time and runs it on a single shared 32-step shift-add / restoring-subtract datapath. While the operation runs it drives the stall request that freezes the pipeline. When the operation finishes it presents a one-cycle write-back result to the execute-stage result mux.

---
 rtl/muldiv_pkg.sv | 27 ++
 rtl/muldiv_step.sv | 27 ++
 rtl/muldiv_seq.sv | 134 +++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared RV32M funct3 codes, sequencer state encoding and operand-sign helpers.
package muldiv_pkg;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_DONE} state_e;

    function automatic logic is_div(input logic [2:0] f3);
        return f3[2];
    endfunction

    function automatic logic is_signed_op1(input logic [2:0] f3);
        return !(f3 == F3_MULHU || f3 == F3_DIVU || f3 == F3_REMU);
    endfunction

    function automatic logic is_signed_op2(input logic [2:0] f3);
        return f3 == F3_MUL || f3 == F3_MULH || f3 == F3_DIV || f3 == F3_REM;
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational iteration of the shared datapath.
//   is_div_i : 0 = shift-add multiply step, 1 = restoring divide step
//   hi_i/lo_i: accumulator (multiply) or {remainder, quotient} (divide)
//   b_i      : multiplicand or divisor magnitude
//   hi_o/lo_o: register values after the step
module muldiv_step #(
    parameter int XLEN = 32
) (
    input  logic            is_div_i,
    input  logic [XLEN-1:0] hi_i,
    input  logic [XLEN-1:0] lo_i,
    input  logic [XLEN-1:0] b_i,
    output logic [XLEN-1:0] hi_o,
    output logic [XLEN-1:0] lo_o
);

    logic [XLEN:0] sum;
    logic [XLEN:0] trial;

    // The shifted remainder can need XLEN+1 bits; bit XLEN of the trial is the borrow.
    assign sum   = {1'b0, hi_i} + (lo_i[0] ? {1'b0, b_i} : '0);
    assign trial = {hi_i, lo_i[XLEN-1]} - {1'b0, b_i};
    assign hi_o  = is_div_i ? (trial[XLEN] ? {hi_i[XLEN-2:0], lo_i[XLEN-1]} : trial[XLEN-1:0])
                            : sum[XLEN:1];
    assign lo_o  = is_div_i ? {lo_i[XLEN-2:0], ~trial[XLEN]} : {sum[0], lo_i[XLEN-1:1]};

endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative RV32M multiply/divide sequencer for the execute stage.
//   clk_i, rst_ni       : clock, async active-low reset
//   start_i, funct3_i   : M-type instruction valid and operation select
//   op1_i, op2_i        : rs1 / rs2 values
//   flush_i, hold_i     : kill in-flight op / keep result in DONE
//   stall_o             : pipeline stall request
//   result_o, reg_we_o  : one-shot write-back data and enable
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            start_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] op1_i,
    input  logic [XLEN-1:0] op2_i,
    input  logic            flush_i,
    input  logic            hold_i,
    output logic            stall_o,
    output logic [XLEN-1:0] result_o,
    output logic            reg_we_o
);

    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2:0]        f3_q, f3_d;
    logic              neg_q, neg_d, sgn1_q, sgn1_d;
    logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d, b_q, b_d, res_q, res_d;
    logic [XLEN-1:0]   hi_n, lo_n, a1, a2, quo_fix, rem_fix, fix, special;
    logic [2*XLEN-1:0] prod, prod_fix;
    logic              s1, s2, div0, ovf;

    muldiv_step #(.XLEN(XLEN)) u_step (
        .is_div_i (is_div(f3_q)),
        .hi_i     (hi_q),
        .lo_i     (lo_q),
        .b_i      (b_q),
        .hi_o     (hi_n),
        .lo_o     (lo_n)
    );

    assign s1      = is_signed_op1(funct3_i) & op1_i[XLEN-1];
    assign s2      = is_signed_op2(funct3_i) & op2_i[XLEN-1];
    assign a1      = s1 ? -op1_i : op1_i;
    assign a2      = s2 ? -op2_i : op2_i;
    assign div0    = is_div(funct3_i) && op2_i == '0;
    assign ovf     = (funct3_i == F3_DIV || funct3_i == F3_REM) && op1_i == SMIN && op2_i == '1;
    assign special = div0 ? (funct3_i[1] ? op1_i : '1) : (funct3_i[1] ? '0 : SMIN);

    // Fix-up is taken from the step outputs so the final iteration and the sign
    // correction land in res_q on the same edge that enters DONE.
    assign prod     = {hi_n, lo_n};
    assign prod_fix = neg_q ? -prod : prod;
    assign quo_fix  = neg_q ? -lo_n : lo_n;
    assign rem_fix  = sgn1_q ? -hi_n : hi_n;
    assign fix      = is_div(f3_q) ? (f3_q[1] ? rem_fix : quo_fix)
                                   : (f3_q == F3_MUL ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN]);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        f3_d    = f3_q;
        neg_d   = neg_q;
        sgn1_d  = sgn1_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        b_d     = b_q;
        res_d   = res_q;
        unique case (state_q)
            ST_IDLE: if (start_i && !flush_i) begin
                f3_d   = funct3_i;
                sgn1_d = s1;
                neg_d  = s1 ^ s2;
                hi_d   = '0;
                lo_d   = a1;
                b_d    = a2;
                if (div0 || ovf) begin
                    res_d   = special;
                    state_d = ST_DONE;
                end else begin
                    cnt_d   = CW'(XLEN - 1);
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                hi_d = hi_n;
                lo_d = lo_n;
                if (cnt_q == '0) begin
                    res_d   = fix;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_DONE: state_d = hold_i ? ST_DONE : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (flush_i) state_d = ST_IDLE;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            f3_q    <= '0;
            neg_q   <= 1'b0;
            sgn1_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            b_q     <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            f3_q    <= f3_d;
            neg_q   <= neg_d;
            sgn1_q  <= sgn1_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            b_q     <= b_d;
            res_q   <= res_d;
        end
    end

    assign stall_o  = ((state_q == ST_IDLE) & start_i & ~flush_i) | ((state_q == ST_CALC) & ~flush_i);
    assign reg_we_o = (state_q == ST_DONE) & ~flush_i;
    assign result_o = (state_q == ST_DONE) ? res_q : '0;

endmodule
